// File: rtl/avmm_lvds_bridge_rx_packer.sv
// rtl/avmm_lvds_bridge_rx_packer.sv - narrow-to-wide slice packer with FWFT output FIFO
// Slices from the LVDS deserializer are assembled LSB-first into DATA_W words and queued.
module avmm_lvds_bridge_rx_packer #(
  parameter int DATA_W = 32,
  parameter int FACTOR = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [DATA_W/FACTOR-1:0]   data_i,
  input  logic                       valid_i,
  input  logic                       sync_i,
  output logic [DATA_W-1:0]          q_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i,
  output logic                       align_err_o
);

  localparam int SW = DATA_W / FACTOR;
  localparam int CW = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     eff_cnt;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_next;
  logic              last;
  logic              realign;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [LW-1:0]     level;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              overflow;
  logic              align_err;

  // A qualified sync restarts assembly at slice 0; any partial word is simply overwritten.
  always_comb begin
    eff_cnt  = cnt;
    realign  = 1'b0;
    if (valid_i && sync_i) begin
      eff_cnt = '0;
      realign = (cnt != '0);
    end
    asm_next = asm_q;
    if (valid_i) begin
      asm_next[int'(eff_cnt)*SW +: SW] = data_i;
    end
    last = valid_i && (eff_cnt == CW'(FACTOR - 1));
  end

  always_comb begin
    full = (level == LW'(DEPTH));
    pop  = (level != '0) && ready_i;
    push = last && (!full || pop);
    drop = last && full && !pop;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt       <= '0;
      align_err <= 1'b0;
    end else begin
      align_err <= realign;
      if (valid_i) begin
        cnt <= last ? '0 : eff_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      asm_q <= asm_next;
    end
  end

  // Storage is not reset; the pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= asm_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // A fresh drop wins over a coincident clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf_i) begin
        overflow <= 1'b0;
      end
    end
  end

  assign q_o         = mem[rptr];
  assign valid_o     = (level != '0);
  assign level_o     = level;
  assign overflow_o  = overflow;
  assign align_err_o = align_err;

endmodule

// File: tb/tb_avmm_lvds_bridge_rx_packer.sv
// tb/tb_avmm_lvds_bridge_rx_packer.sv - scoreboard bench for the rx slice packer
// Expected words are queued as slices are driven and compared as the FIFO delivers them.
module tb_avmm_lvds_bridge_rx_packer;

  localparam int DATA_W = 32;
  localparam int FACTOR = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        sync;
  logic [31:0] q;
  logic        valid_o;
  logic        ready;
  logic [2:0]  level;
  logic        overflow;
  logic        clr_ovf;
  logic        align_err;

  int          checks = 0;
  int          errors = 0;
  int          align_pulses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  avmm_lvds_bridge_rx_packer #(
    .DATA_W(DATA_W),
    .FACTOR(FACTOR),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .data_i     (data),
    .valid_i    (valid),
    .sync_i     (sync),
    .q_o        (q),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .level_o    (level),
    .overflow_o (overflow),
    .clr_ovf_i  (clr_ovf),
    .align_err_o(align_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Outputs sampled on the falling edge; a handshake seen here pops on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && align_err) align_pulses++;
    if (rst_n && valid_o && ready) begin
      check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("sb_word", q, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_slice(input logic [7:0] d, input logic s);
    data  = d;
    sync  = s;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    sync  = 1'b0;
    data  = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap, input bit stored);
    for (int i = 0; i < 4; i++) begin
      send_slice(w[i*8 +: 8], i == 0);
      if (i < 3 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
    if (stored) exp_q.push_back(w);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    data    = '0;
    valid   = 1'b0;
    sync    = 1'b0;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    idle(3);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_align", 32'(align_err), 32'd0);
    rst_n = 1'b1;

    // Basic word, one-cycle latency, single-cycle valid with ready held high.
    ready = 1'b1;
    send_word(32'h44332211, 0, 1'b1);
    check_eq("basic_valid_first", 32'(valid_o), 32'd1);
    check_eq("basic_q", q, 32'h44332211);
    idle(1);
    check_eq("basic_valid_after", 32'(valid_o), 32'd0);

    // Mid-word sync discards the partial word and pulses align_err once.
    send_slice(8'hAA, 1'b1);
    send_slice(8'hBB, 1'b0);
    send_slice(8'h01, 1'b1);
    check_eq("align_pulse", 32'(align_err), 32'd1);
    send_slice(8'h02, 1'b0);
    check_eq("align_drop", 32'(align_err), 32'd0);
    send_slice(8'h03, 1'b0);
    send_slice(8'h04, 1'b0);
    exp_q.push_back(32'h04030201);
    idle(3);
    check_eq("align_drained", 32'(exp_q.size()), 32'd0);
    check_eq("align_count", 32'(align_pulses), 32'd1);

    // Overflow: fifth word dropped, first four returned in order.
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_word(32'h01010101 * k, 0, k <= 4);
    check_eq("ovf_level", 32'(level), 32'd4);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    drain();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check_eq("ovf_clear", 32'(overflow), 32'd0);

    // Clear coinciding with a new drop leaves overflow set.
    ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(32'hA0A0A0A0 + k, 0, 1'b1);
    send_slice(8'h55, 1'b1);
    send_slice(8'h66, 1'b0);
    send_slice(8'h77, 1'b0);
    clr_ovf = 1'b1;
    send_slice(8'h88, 1'b0);
    clr_ovf = 1'b0;
    check_eq("ovf_clr_race", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check_eq("ovf_clear2", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop: nothing lost, no overflow.
    send_slice(8'hC1, 1'b1);
    send_slice(8'hC2, 1'b0);
    send_slice(8'hC3, 1'b0);
    ready = 1'b1;
    send_slice(8'hC4, 1'b0);
    ready = 1'b0;
    exp_q.push_back(32'hC4C3C2C1);
    check_eq("full_pp_level", 32'(level), 32'd4);
    check_eq("full_pp_ovf", 32'(overflow), 32'd0);
    drain();

    // Idle gaps between slices do not change the assembled words.
    for (int k = 0; k < 4; k++) send_word($urandom, 3, 1'b1);
    drain();

    // Reset mid-operation discards partial and stored words.
    ready = 1'b0;
    send_word(32'h0BADF00D, 0, 1'b1);
    send_word(32'hDEADBEEF, 0, 1'b1);
    check_eq("pre_rst_level", 32'(level), 32'd2);
    send_slice(8'hE1, 1'b1);
    send_slice(8'hE2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    exp_q.delete();
    idle(1);
    rst_n = 1'b1;
    ready = 1'b1;
    send_slice(8'hD1, 1'b0);
    send_slice(8'hD2, 1'b0);
    send_slice(8'hD3, 1'b0);
    send_slice(8'hD4, 1'b0);
    exp_q.push_back(32'hD4D3D2D1);
    drain();
    check_eq("post_rst_level", 32'(level), 32'd0);
    check_eq("align_total", 32'(align_pulses), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
